// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RV32 loads and stores into accesses on a
// word-wide memory. Sub-word stores use read-modify-write. One transaction is in
// flight at a time.
// Optional macro LSU_ERR_EN enables misalignment/illegal-funct3 error reporting;
// without it, addresses are forced to natural alignment and illegal codes act as LW/SW.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADD_WIDTH     = 16,
    parameter int unsigned ADDR_IN_WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic                     REQ_WRITE,
    input  logic [2:0]               REQ_FUNCT3,
    input  logic [ADDR_IN_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]    REQ_WDATA,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [DATA_WIDTH-1:0]    RSP_RDATA,
    output logic                     RSP_ERR,
    output logic [ADD_WIDTH-1:0]     MEM_ADDRESS,
    output logic                     MEM_WRITE_READ,
    output logic [DATA_WIDTH-1:0]    MEM_WRITE_DATA,
    input  logic [DATA_WIDTH-1:0]    MEM_READ_DATA
);

    // Byte address bits actually kept: word address plus the lane offset.
    localparam int unsigned AW = ADD_WIDTH + 2;

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRead, StWrite, StResp} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              funct3_q;
    logic [AW-1:0]           addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;   // store data, overwritten by the merged word on RMW
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    accept;
    logic                    illegal;
    logic                    req_err;
    logic [2:0]              req_f3;
    logic [1:0]              req_lo;
    logic [7:0]              lane_b;
    logic [15:0]             lane_h;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [DATA_WIDTH-1:0]   merge_data;

    // Address bits above the memory space wrap and are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^REQ_ADDR[ADDR_IN_WIDTH-1:AW];

    assign accept = REQ_VALID & (state_q == StIdle);

`ifdef LSU_ERR_EN
    logic misaligned;
    logic err_q;
`endif

    // Classify the incoming request: error flag, or normalised funct3/alignment.
    always_comb begin
        req_f3  = REQ_FUNCT3;
        req_lo  = REQ_ADDR[1:0];
        req_err = 1'b0;
        if (REQ_WRITE) begin
            illegal = REQ_FUNCT3[2] | (REQ_FUNCT3[1:0] == 2'b11);
        end else begin
            illegal = (REQ_FUNCT3[1:0] == 2'b11) | (REQ_FUNCT3[2:1] == 2'b11);
        end
`ifdef LSU_ERR_EN
        misaligned = ((REQ_FUNCT3[1:0] == 2'b01) & REQ_ADDR[0]) |
                     ((REQ_FUNCT3[1:0] == 2'b10) & (REQ_ADDR[1:0] != 2'b00));
        req_err    = illegal | misaligned;
`else
        if (illegal) begin
            req_f3 = 3'b010;
        end
        if (req_f3[1:0] == 2'b01) begin
            req_lo[0] = 1'b0;
        end else if (req_f3[1:0] == 2'b10) begin
            req_lo = 2'b00;
        end
`endif
    end

    // Lane select and sign/zero extension of the memory read word.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = MEM_READ_DATA[7:0];
            2'd1:    lane_b = MEM_READ_DATA[15:8];
            2'd2:    lane_b = MEM_READ_DATA[23:16];
            default: lane_b = MEM_READ_DATA[31:24];
        endcase
        lane_h = addr_q[1] ? MEM_READ_DATA[31:16] : MEM_READ_DATA[15:0];
        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
            3'b001:  load_data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
            default: load_data = MEM_READ_DATA;
        endcase
    end

    // Replace the target byte/half lane of the read word with the store data.
    always_comb begin
        merge_data = MEM_READ_DATA;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_data[31:16] = wdata_q[15:0];
        end else begin
            merge_data[15:0] = wdata_q[15:0];
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (REQ_VALID) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (!REQ_WRITE) begin
                        state_d = StLoad;
                    end else if (req_f3[1:0] == 2'b10) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRead;
                    end
                end
            end
            StLoad:    state_d = StResp;
            StRmwRead: state_d = StWrite;
            StWrite:   state_d = StResp;
            StResp:    if (RSP_READY) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs, decoded from the registered state only.
    always_comb begin
        REQ_READY      = (state_q == StIdle);
        RSP_VALID      = (state_q == StResp);
        MEM_WRITE_READ = (state_q == StWrite);
        MEM_WRITE_DATA = (state_q == StWrite) ? wdata_q : '0;
    end

    // Request latch, load result capture and RMW merge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef LSU_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                funct3_q <= req_f3;
                addr_q   <= {REQ_ADDR[AW-1:2], req_lo};
                wdata_q  <= REQ_WDATA;
                rdata_q  <= '0;
`ifdef LSU_ERR_EN
                err_q    <= req_err;
`endif
            end
            if (state_q == StLoad) begin
                rdata_q <= load_data;
            end
            if (state_q == StRmwRead) begin
                wdata_q <= merge_data;
            end
        end
    end

    assign MEM_ADDRESS = addr_q[AW-1:2];
    assign RSP_RDATA   = rdata_q;
`ifdef LSU_ERR_EN
    assign RSP_ERR     = err_q;
`else
    assign RSP_ERR     = 1'b0;
`endif

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute/memory pipeline stage and the word-wide data memory. It drives the memory's address, write-enable and write-data lines and consumes its combinational read data.
- Converts byte-addressed RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Loads are sign- or zero-extended; sub-word stores use read-modify-write, because the memory only writes full words.
- Requests and responses use valid/ready handshakes, with one transaction in flight at a time.

Parameters:
- DATA_WIDTH, 32, data path width; fixed at 32 for RV32 semantics.
- ADD_WIDTH, 16, memory word-address width driven to the memory.
- ADDR_IN_WIDTH, 32, byte address width from the pipeline.

Ports:
- CLK  input  1  global clock; all state updates on posedge.
- RESET  input  1  global reset, asynchronous, active-high.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  unit can accept a request; high only in IDLE.
- REQ_WRITE  input  1  1 = store, 0 = load.
- REQ_FUNCT3  input  3  RISC-V funct3 size/sign code.
- REQ_ADDR  input  ADDR_IN_WIDTH  byte address.
- REQ_WDATA  input  DATA_WIDTH  store data, right-aligned.
- RSP_VALID  output  1  response present.
- RSP_READY  input  1  consumer accepts response.
- RSP_RDATA  output  DATA_WIDTH  extended load data; 0 for stores.
- RSP_ERR  output  1  misaligned or illegal funct3.
- MEM_ADDRESS  output  ADD_WIDTH  word address, equal to latched REQ_ADDR[ADD_WIDTH+1:2].
- MEM_WRITE_READ  output  1  memory write enable.
- MEM_WRITE_DATA  output  DATA_WIDTH  merged word to write.
- MEM_READ_DATA  input  DATA_WIDTH  memory combinational read data.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - REQ_READY = 1.
  - RSP_VALID, RSP_ERR, MEM_WRITE_READ = 0.
  - RSP_RDATA, MEM_ADDRESS, MEM_WRITE_DATA = 0.
  - Reset during any state aborts the transaction; no memory write occurs after RESET asserts.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE: accept when REQ_VALID & REQ_READY. Latch write, funct3, addr and wdata, then check for errors:
  - Illegal load funct3: 011, 110, 111.
  - Illegal store funct3: anything other than 000, 001, 010.
  - Misaligned: half access with addr[0] = 1, or word access with addr[1:0] != 0.
  - On error: go to RESP with RSP_ERR = 1 and RSP_RDATA = 0; no memory access.
  - Otherwise: load -> LOAD; SW -> WRITE; SB/SH -> RMW_READ.
- LOAD:
  - MEM_ADDRESS = latched word address; MEM_WRITE_READ = 0.
  - At the clock edge, select the byte/half using addr[1:0]/addr[1], extend per funct3, register into RSP_RDATA, then go to RESP.
  - Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- RMW_READ: capture MEM_READ_DATA into a merge register, replace the target lane (byte lane addr[1:0] or half lane addr[1]) with the low bits of wdata, then go to WRITE.
- WRITE:
  - MEM_WRITE_READ = 1 for exactly one cycle.
  - MEM_WRITE_DATA = merged word (SB/SH) or latched wdata (SW).
  - Then go to RESP.
- MEM_WRITE_READ is decoded from the registered state only and is never high outside WRITE.
- RESP:
  - RSP_VALID = 1; RSP_RDATA and RSP_ERR are held stable.
  - Leave for IDLE on RSP_VALID & RSP_READY.
  - A new request can be accepted the cycle after the response handshake; there is no same-cycle back-to-back.
- Latency from the accept edge to RSP_VALID high:
  - Load: 2 edges.
  - SW: 2 edges.
  - SB/SH: 3 edges.
  - Error: 1 edge.
- MEM_ADDRESS holds the last latched word address in IDLE; its value there is don't-care because the memory sees no write.
- Address bits above ADD_WIDTH+1 are ignored (they wrap into the memory space).

Optional Feature:
- Macro LSU_ERR_EN.
- Defined: the misaligned/illegal checks above are active and RSP_ERR is driven.
- Undefined:
  - RSP_ERR is tied 0.
  - Misaligned addresses are forced to natural alignment: addr[0] cleared for half accesses, addr[1:0] cleared for word accesses.
  - Illegal load funct3 is treated as LW; illegal store funct3 is treated as SW.
  - No transaction ever skips memory access.

Test Plan:
- Reset mid-operation: assert RESET while in WRITE -> MEM_WRITE_READ drops the same cycle, memory word unchanged, REQ_READY = 1, RSP_VALID = 0.
- SW then LW: SW addr 0x10, data 0xDEADBEEF -> one write pulse with MEM_ADDRESS = 4. LW addr 0x10 -> RSP_RDATA = 0xDEADBEEF, RSP_ERR = 0, RSP_VALID 2 edges after accept.
- Sub-word loads on word 0x80F1_7F02 at addr 0x20:
  - LB 0x21 -> 0x0000007F.
  - LB 0x23 -> 0xFFFFFF80.
  - LBU 0x23 -> 0x00000080.
  - LH 0x22 -> 0xFFFF80F1.
  - LHU 0x22 -> 0x000080F1.
- RMW stores: word 0x11223344 at addr 0x30.
  - SB 0x31 with data 0xAA -> memory 0x1122AA44; exactly one write pulse, response 3 edges after accept.
  - SH 0x32 with data 0xBEEF -> memory 0xBEEFAA44.
- Errors (LSU_ERR_EN defined):
  - LW 0x13 -> RSP_ERR = 1, RSP_RDATA = 0, no write.
  - SH 0x31 -> RSP_ERR = 1, memory unchanged.
  - Load funct3 = 011 -> RSP_ERR = 1.
- Handshake backpressure: hold RSP_READY = 0 for 5 cycles during a load -> RSP_VALID and RSP_RDATA stay stable and REQ_READY = 0. Then assert RSP_READY -> IDLE the next cycle, and a queued REQ_VALID is accepted one cycle later.
